// File: rtl/program_loader_pkg.sv
// ----------------------------------------------------------------------------
// program_loader_pkg
// Shared definitions for the program loader: default parameter values, the
// loader FSM state type and a word-index to byte-address helper.
// Ports: none (package).
// ----------------------------------------------------------------------------
package program_loader_pkg;

    localparam int unsigned DefMemoryDepth   = 32;
    localparam int unsigned DefTimeoutCycles = 1000;
    localparam logic [7:0]  DefSyncByte      = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StData,
        StCheck,
        StDone,
        StError
    } state_e;

    // Program memory is addressed like the PC: word index * 4.
    function automatic logic [31:0] word_byte_addr(input logic [31:0] idx);
        return idx << 2;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// ----------------------------------------------------------------------------
// program_loader_if
// Bundles the host byte link, the program memory write port and the loader
// status outputs.
//   rx_data/rx_valid/rx_ready : byte stream from host (accepted on valid&&ready)
//   mem_we/mem_addr/mem_wdata : program memory write port
//   cpu_hold                  : holds the processor in reset
//   load_done/load_error      : one-cycle completion pulses
// Modports:
//   master : environment side (host byte source, memory/status observer)
//   slave  : loader side
// ----------------------------------------------------------------------------
interface program_loader_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  cpu_hold,
        input  load_done,
        input  load_error
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output cpu_hold,
        output load_done,
        output load_error
    );

endinterface

// File: rtl/program_loader_word_assembler.sv
// ----------------------------------------------------------------------------
// program_loader_word_assembler
// Collects four bytes little-endian (first byte lands in [7:0]) into a 32-bit
// word. Only the first three bytes are stored; the word is completed
// combinationally with the fourth byte so word_ready_o coincides with it.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   clear_i        : restart assembly (drops any partial word)
//   byte_valid_i   : byte_i is consumed this cycle
//   byte_i         : incoming byte
//   word_o         : assembled word, valid while word_ready_o is high
//   word_ready_o   : pulse, fourth byte of a word consumed this cycle
// ----------------------------------------------------------------------------
module program_loader_word_assembler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;

    assign word_o       = {byte_i, shift_q};
    assign word_ready_o = byte_valid_i && (cnt_q == 2'd3);

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear_i) begin
            cnt_d   = 2'd0;
            shift_d = 24'd0;
        end else if (byte_valid_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {byte_i, shift_q[23:8]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// ----------------------------------------------------------------------------
// program_loader
// Receives a framed byte stream (SYNC, COUNT, COUNT*4 data bytes, CHECK) and
// writes the decoded 32-bit words into program memory at word index * 4.
// Holds the processor in reset from SYNC until a frame completes cleanly.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : program_loader_if.slave (byte link, memory write port, status)
// ----------------------------------------------------------------------------
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned MemoryDepth   = DefMemoryDepth,
    parameter int unsigned TimeoutCycles = DefTimeoutCycles,
    parameter logic [7:0]  SyncByte      = DefSyncByte
) (
    input  logic             clk,
    input  logic             reset,
    program_loader_if.slave  bus
);

    localparam int unsigned IdxW = $clog2(MemoryDepth + 1);
    localparam int unsigned TmrW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   count_q, count_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [7:0]        sum_q, sum_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic              hold_q, hold_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              rx_ready;
    logic              accept;
    logic              timeout_hit;
    logic              asm_clear;
    logic              asm_valid;
    logic [31:0]       asm_word;
    logic              asm_word_ready;

    assign rx_ready    = (state_q == StIdle) || (state_q == StCount) ||
                         (state_q == StData) || (state_q == StCheck);
    assign accept      = bus.rx_valid && rx_ready;
    assign timeout_hit = (tmr_q == TmrW'(TimeoutCycles - 1));
    assign asm_clear   = accept && (state_q == StCount);
    assign asm_valid   = accept && (state_q == StData);

    program_loader_word_assembler u_word_assembler (
        .clk_i        (clk),
        .rst_i        (reset),
        .clear_i      (asm_clear),
        .byte_valid_i (asm_valid),
        .byte_i       (bus.rx_data),
        .word_o       (asm_word),
        .word_ready_o (asm_word_ready)
    );

    // Write port registers: strobe one cycle after the fourth byte of a word;
    // address/data hold their last written values between strobes.
    always_comb begin
        we_d    = asm_word_ready;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (asm_word_ready) begin
            addr_d  = word_byte_addr(32'(idx_q));
            wdata_d = asm_word;
        end
    end

    // Idle timer only runs inside a frame; any accepted byte restarts it.
    always_comb begin
        tmr_d = '0;
        if ((state_q == StCount) || (state_q == StData) || (state_q == StCheck)) begin
            tmr_d = accept ? '0 : tmr_q + TmrW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if (accept && (bus.rx_data == SyncByte)) begin
                    state_d = StCount;
                    hold_d  = 1'b1;
                end
            end
            StCount: begin
                if (accept) begin
                    if ((bus.rx_data == 8'd0) || (32'(bus.rx_data) > MemoryDepth)) begin
                        state_d = StError;
                    end else begin
                        count_d = IdxW'(bus.rx_data);
                        idx_d   = '0;
                        sum_d   = 8'd0;
                        state_d = StData;
                    end
                end else if (timeout_hit) begin
                    state_d = StError;
                end
            end
            StData: begin
                if (accept) begin
                    sum_d = sum_q + bus.rx_data;
                    if (asm_word_ready) begin
                        idx_d = idx_q + IdxW'(1);
                        if (idx_q == count_q - IdxW'(1)) begin
                            state_d = StCheck;
                        end
                    end
                end else if (timeout_hit) begin
                    state_d = StError;
                end
            end
            StCheck: begin
                if (accept) begin
                    if (bus.rx_data == sum_q) begin
                        state_d = StDone;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = StError;
                    end
                end else if (timeout_hit) begin
                    state_d = StError;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StError: begin
                // cpu_hold deliberately left set: the image in memory is corrupt.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            idx_q   <= '0;
            sum_q   <= 8'd0;
            tmr_q   <= '0;
            hold_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            tmr_q   <= tmr_d;
            hold_q  <= hold_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.rx_ready   = rx_ready;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.cpu_hold   = hold_q;
    assign bus.load_done  = (state_q == StDone);
    assign bus.load_error = (state_q == StError);

endmodule
